// File: rtl/alu_issue_ctrl.sv
// Issue/collect front-end for the 16-bit registered ALU: tagged requests in, in-order tagged results out.
// Optional ALU_ISSUE_PERF_EN adds perf_issued / perf_div0 event counters.
module alu_issue_ctrl #(
   parameter int CELL_SIZE = 16,
   parameter int TAG_W     = 4,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [CELL_SIZE-1:0] req_lhs,
   input  logic [CELL_SIZE-1:0] req_rhs,
   input  logic [TAG_W-1:0]     req_tag,
   output logic [2:0]           alu_op,
   output logic [CELL_SIZE-1:0] alu_lhs,
   output logic [CELL_SIZE-1:0] alu_rhs,
   input  logic [CELL_SIZE-1:0] alu_result,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CELL_SIZE-1:0] rsp_result,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_err
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]          perf_issued,
   output logic [15:0]          perf_div0
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshakes: a transfer happens at a rising edge where valid && ready are both high;
   // ready never depends combinationally on valid, and a held valid keeps its payload stable.

   logic [2:0]           alu_op_q, alu_op_d;
   logic [CELL_SIZE-1:0] alu_lhs_q, alu_lhs_d;
   logic [CELL_SIZE-1:0] alu_rhs_q, alu_rhs_d;
   logic                 s1_valid_q, s1_valid_d;
   logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;
   logic                 s1_err_q, s1_err_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [TAG_W-1:0]     s2_tag_q, s2_tag_d;
   logic                 s2_err_q, s2_err_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [CELL_SIZE-1:0] mem_res_q [DEPTH];
   logic [CELL_SIZE-1:0] mem_res_d [DEPTH];
   logic [TAG_W-1:0]     mem_tag_q [DEPTH];
   logic [TAG_W-1:0]     mem_tag_d [DEPTH];
   logic                 mem_err_q [DEPTH];
   logic                 mem_err_d [DEPTH];
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0]          perf_issued_q, perf_issued_d;
   logic [15:0]          perf_div0_q, perf_div0_d;
`endif

   logic [CNT_W:0] reserved;
   logic           accept;
   logic           push;
   logic           pop;
   logic           req_div0;

   // Credits cover FIFO entries plus both in-flight stages, so a push always finds room.
   assign reserved  = {1'b0, count_q} + (CNT_W+1)'(s1_valid_q) + (CNT_W+1)'(s2_valid_q);
   assign req_ready = reserved < (CNT_W+1)'(DEPTH);
   assign accept    = req_valid && req_ready;
   assign push      = s2_valid_q;
   assign pop       = rsp_valid && rsp_ready;
   assign req_div0  = ((req_op == 3'b011) || (req_op == 3'b100)) && (req_rhs == '0);

   always_comb begin
      alu_op_d   = alu_op_q;
      alu_lhs_d  = alu_lhs_q;
      alu_rhs_d  = alu_rhs_q;
      s1_valid_d = accept;
      s1_tag_d   = s1_tag_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      s2_err_d   = s1_err_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_res_d  = mem_res_q;
      mem_tag_d  = mem_tag_q;
      mem_err_d  = mem_err_q;
`ifdef ALU_ISSUE_PERF_EN
      perf_issued_d = perf_issued_q;
      perf_div0_d   = perf_div0_q;
`endif

      if (accept) begin
         alu_op_d  = req_op;
         alu_lhs_d = req_lhs;
         alu_rhs_d = req_rhs;
         s1_tag_d  = req_tag;
         s1_err_d  = req_div0;
`ifdef ALU_ISSUE_PERF_EN
         perf_issued_d = perf_issued_q + 32'd1;
         if (req_div0) perf_div0_d = perf_div0_q + 16'd1;
`endif
      end

      // The ALU result for a div/mod by zero is meaningless; store all-ones instead.
      if (push) begin
         mem_res_d[wr_ptr_q] = s2_err_q ? {CELL_SIZE{1'b1}} : alu_result;
         mem_tag_d[wr_ptr_q] = s2_tag_q;
         mem_err_d[wr_ptr_q] = s2_err_q;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end

      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_op_q   <= '0;
         alu_lhs_q  <= '0;
         alu_rhs_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
         s2_err_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         mem_res_q  <= '{default: '0};
         mem_tag_q  <= '{default: '0};
         mem_err_q  <= '{default: 1'b0};
`ifdef ALU_ISSUE_PERF_EN
         perf_issued_q <= '0;
         perf_div0_q   <= '0;
`endif
      end else begin
         alu_op_q   <= alu_op_d;
         alu_lhs_q  <= alu_lhs_d;
         alu_rhs_q  <= alu_rhs_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
         s2_err_q   <= s2_err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_res_q  <= mem_res_d;
         mem_tag_q  <= mem_tag_d;
         mem_err_q  <= mem_err_d;
`ifdef ALU_ISSUE_PERF_EN
         perf_issued_q <= perf_issued_d;
         perf_div0_q   <= perf_div0_d;
`endif
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_lhs    = alu_lhs_q;
   assign alu_rhs    = alu_rhs_q;
   assign rsp_valid  = (count_q != '0);
   assign rsp_result = mem_res_q[rd_ptr_q];
   assign rsp_tag    = mem_tag_q[rd_ptr_q];
   assign rsp_err    = mem_err_q[rd_ptr_q];
`ifdef ALU_ISSUE_PERF_EN
   assign perf_issued = perf_issued_q;
   assign perf_div0   = perf_div0_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: registered ALU model, directed vector table, corner sequences and a random stream
// checked against an in-order response queue; perf counters checked when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_lhs;
   logic [15:0] req_rhs;
   logic [3:0]  req_tag;
   logic [2:0]  alu_op;
   logic [15:0] alu_lhs;
   logic [15:0] alu_rhs;
   logic [15:0] alu_result = '0;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [15:0] perf_div0;
   int          mdl_issued;
   int          mdl_div0;
`endif

   alu_issue_ctrl #(.CELL_SIZE(16), .TAG_W(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_lhs(req_lhs), .req_rhs(req_rhs), .req_tag(req_tag),
      .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err)
`ifdef ALU_ISSUE_PERF_EN
      , .perf_issued(perf_issued), .perf_div0(perf_div0)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- check helpers ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // ---------------- golden arithmetic ----------------
   function automatic logic [15:0] golden(input logic [2:0] op, input logic [15:0] l, input logic [15:0] r);
      logic [31:0] p;
      p = 32'(l) * 32'(r);
      case (op)
         3'd0: return l + r;
         3'd1: return l - r;
         3'd2: return p[15:0];
         3'd3: return (r == 0) ? 16'hFFFF : l / r;
         3'd4: return (r == 0) ? 16'hFFFF : l % r;
         3'd5: return l & r;
         3'd6: return l | r;
         default: return l ^ r;
      endcase
   endfunction

   // External registered ALU: samples its inputs every edge; div/mod by zero yields 0.
   always @(posedge clk) begin
      if ((alu_op == 3'd3 || alu_op == 3'd4) && alu_rhs == 0) alu_result <= 16'h0000;
      else alu_result <= golden(alu_op, alu_lhs, alu_rhs);
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [15:0] res;
      logic [3:0]  tag;
      logic        err;
      int          acc_edge;
   } exp_t;

   exp_t        exp_q[$];
   logic [2:0]  last_op;
   logic [15:0] last_lhs;
   logic [15:0] last_rhs;
   bit          mon_en = 1'b0;

   task automatic model_reset();
      exp_q.delete();
      last_op  = '0;
      last_lhs = '0;
      last_rhs = '0;
`ifdef ALU_ISSUE_PERF_EN
      mdl_issued = 0;
      mdl_div0   = 0;
`endif
   endtask

   // Outputs are compared mid-cycle; inputs are stable here, so this also decides what the next edge transfers.
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         bit   exp_rdy;
         bit   exp_rv;
         exp_t e;
         exp_rdy = exp_q.size() < DEPTH;
         exp_rv  = (exp_q.size() > 0) && (cyc >= exp_q[0].acc_edge + 2);
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         chk("alu_op", 32'(alu_op), 32'(last_op));
         chk("alu_lhs", 32'(alu_lhs), 32'(last_lhs));
         chk("alu_rhs", 32'(alu_rhs), 32'(last_rhs));
         if (exp_rv && rsp_valid) begin
            chk("rsp_result", 32'(rsp_result), 32'(exp_q[0].res));
            chk("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
            chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
         end
`ifdef ALU_ISSUE_PERF_EN
         chk("perf_issued", perf_issued, 32'(mdl_issued));
         chk("perf_div0", 32'(perf_div0), 32'(mdl_div0[15:0]));
`endif
         if (exp_rv && rsp_ready) void'(exp_q.pop_front());
         if (req_valid && exp_rdy) begin
            e.err      = (req_op == 3'd3 || req_op == 3'd4) && (req_rhs == 0);
            e.res      = golden(req_op, req_lhs, req_rhs);
            e.tag      = req_tag;
            e.acc_edge = cyc + 1;
            exp_q.push_back(e);
            last_op  = req_op;
            last_lhs = req_lhs;
            last_rhs = req_rhs;
`ifdef ALU_ISSUE_PERF_EN
            mdl_issued++;
            if (e.err) mdl_div0++;
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   bit rnd_bp = 1'b0;

   // Called just after a rising edge; returns just after the edge that accepted the request.
   task automatic issue(input logic [2:0] op, input logic [15:0] l, input logic [15:0] r,
                        input logic [3:0] t, output int waits);
      req_op    = op;
      req_lhs   = l;
      req_rhs   = r;
      req_tag   = t;
      req_valid = 1'b1;
      waits     = 0;
      @(negedge clk);
      while (!req_ready) begin
         if (waits >= 60) begin
            timeout("issue_accept");
            break;
         end
         waits++;
         @(posedge clk); #1;
         if (rnd_bp) rsp_ready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rsp_ready = 1'b1;
      while ((exp_q.size() > 0 || rsp_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) timeout("drain");
      @(posedge clk); #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0]  op;
      logic [15:0] lhs;
      logic [15:0] rhs;
      logic [3:0]  tag;
      logic [15:0] res;
      logic        err;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int w;
      int lat;
      int n_acc;
      bit acc;
      logic [3:0] t;

      tbl[0]  = '{3'd0, 16'd7,     16'd5,     4'd3,  16'd12,    1'b0};
      tbl[1]  = '{3'd1, 16'd10,    16'd3,     4'd4,  16'd7,     1'b0};
      tbl[2]  = '{3'd7, 16'h00F0,  16'h0FF0,  4'd5,  16'h0F00,  1'b0};
      tbl[3]  = '{3'd3, 16'd9,     16'd0,     4'd1,  16'hFFFF,  1'b1};
      tbl[4]  = '{3'd4, 16'd9,     16'd4,     4'd2,  16'd1,     1'b0};
      tbl[5]  = '{3'd2, 16'd300,   16'd300,   4'd6,  16'h5F90,  1'b0};
      tbl[6]  = '{3'd1, 16'd0,     16'd1,     4'd7,  16'hFFFF,  1'b0};
      tbl[7]  = '{3'd4, 16'd5,     16'd0,     4'd8,  16'hFFFF,  1'b1};
      tbl[8]  = '{3'd5, 16'hF0F0,  16'h0FF0,  4'd9,  16'h00F0,  1'b0};
      tbl[9]  = '{3'd6, 16'hF000,  16'h000F,  4'd10, 16'hF00F,  1'b0};
      tbl[10] = '{3'd3, 16'd100,   16'd7,     4'd11, 16'd14,    1'b0};
      tbl[11] = '{3'd0, 16'hFFFF,  16'd2,     4'd12, 16'd1,     1'b0};

      // ---- reset ----
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = '0;
      req_lhs   = '0;
      req_rhs   = '0;
      req_tag   = '0;
      rsp_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_alu_op", 32'(alu_op), 32'd0);
      chk("reset_alu_lhs", 32'(alu_lhs), 32'd0);
      chk("reset_alu_rhs", 32'(alu_rhs), 32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(posedge clk); #1;

      // ---- directed table: single requests, exact latency ----
      for (int i = 0; i < 12; i++) begin
         issue(tbl[i].op, tbl[i].lhs, tbl[i].rhs, tbl[i].tag, w);
         chk("tbl_alu_op", 32'(alu_op), 32'(tbl[i].op));
         chk("tbl_alu_lhs", 32'(alu_lhs), 32'(tbl[i].lhs));
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!rsp_valid && lat < 10);
         chk("tbl_latency", 32'(lat), 32'd3);
         chk("tbl_result", 32'(rsp_result), 32'(tbl[i].res));
         chk("tbl_tag", 32'(rsp_tag), 32'(tbl[i].tag));
         chk("tbl_err", 32'(rsp_err), 32'(tbl[i].err));
         @(posedge clk); #1;
      end
      drain();

      // ---- back-to-back stream: sub / xor alternating ----
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) issue(3'd1, 16'(10 + i), 16'd3, 4'(i), w);
         else issue(3'd7, 16'h00F0, 16'h0FF0, 4'(i), w);
         chk("stream_no_stall", 32'(w), 32'd0);
      end
      drain();

      // ---- backpressure until full ----
      rsp_ready = 1'b0;
      t         = 4'd0;
      n_acc     = 0;
      req_op    = 3'd0;
      req_lhs   = 16'd100;
      req_rhs   = 16'd1;
      req_tag   = t;
      req_valid = 1'b1;
      repeat (12) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            t++;
            req_op  = 3'($urandom_range(0, 7));
            req_lhs = 16'($urandom);
            req_rhs = 16'($urandom_range(0, 20));
            req_tag = t;
         end
      end
      chk("full_accepts", 32'(n_acc), 32'(DEPTH));
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("ready_pop_cycle", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("ready_after_pop", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;

      // ---- push/pop at full across pointer wrap ----
      rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom_range(0, 9)), 4'(i), w);
      drain();

      // ---- reset mid-operation ----
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(3'd0, 16'(i), 16'd1, 4'(i), w);
      #2;
      reset_n = 1'b0;
      #1;
      mon_en = 1'b0;
      model_reset();
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_alu_op", 32'(alu_op), 32'd0);
      chk("midrst_alu_lhs", 32'(alu_lhs), 32'd0);
      chk("midrst_alu_rhs", 32'(alu_rhs), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
      chk("midrst_perf_issued", perf_issued, 32'd0);
      chk("midrst_perf_div0", 32'(perf_div0), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      mon_en  = 1'b1;
      rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      issue(3'd2, 16'd6, 16'd7, 4'd9, w);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 10);
      chk("post_rst_latency", 32'(lat), 32'd3);
      chk("post_rst_result", 32'(rsp_result), 32'd42);
      chk("post_rst_tag", 32'(rsp_tag), 32'd9);
      @(posedge clk); #1;
      drain();

      // ---- random stream with random backpressure ----
      rnd_bp = 1'b1;
      for (int i = 0; i < 150; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0)
            issue(3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom), 4'($urandom_range(0, 15)), w);
         else begin
            @(posedge clk); #1;
         end
      end
      rnd_bp = 1'b0;
      drain();
      chk("final_empty", 32'(exp_q.size()), 32'd0);
      chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/collect front-end for the 16-bit registered ALU.
- Accepts tagged operation requests on a valid/ready interface and drives the ALU's op/lhs/rhs inputs.
- Tracks the ALU's 1-cycle result latency and captures each result into a response FIFO.
- Returns results downstream in request order on a valid/ready interface, with tag and divide-by-zero error flag.

Parameters:
- CELL_SIZE, 16, operand/result width; matches the ALU.
- TAG_W, 4, width of the request tag carried to the response.
- DEPTH, 4, response FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request may be accepted this cycle.
- req_op  input  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor.
- req_lhs  input  CELL_SIZE  left operand.
- req_rhs  input  CELL_SIZE  right operand.
- req_tag  input  TAG_W  opaque tag, echoed on the response.
- alu_op  output  3  registered opcode to the ALU.
- alu_lhs  output  CELL_SIZE  registered lhs to the ALU.
- alu_rhs  output  CELL_SIZE  registered rhs to the ALU.
- alu_result  input  CELL_SIZE  ALU result register output.
- rsp_valid  output  1  response present (FIFO not empty).
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  CELL_SIZE  result at the FIFO head.
- rsp_tag  output  TAG_W  tag at the FIFO head.
- rsp_err  output  1  head entry was div/mod by zero.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous, active-low.
- Reset values: alu_op, alu_lhs, alu_rhs = 0; both pipeline valid flags = 0; FIFO empty; rsp_valid = 0; req_ready = 1 once reset_n is high.
- Accept: a request is accepted at a rising edge where req_valid && req_ready (edge N).
  - At edge N, alu_op/alu_lhs/alu_rhs load the request; s1_valid, s1_tag and s1_err are set.
  - s1_err = (op == 011 || op == 100) && rhs == 0.
- Edge N+1: the ALU samples its inputs; s1 moves to s2 (s2_valid, s2_tag, s2_err).
- Edge N+2: a FIFO entry is pushed with {alu_result or override, s2_tag, s2_err}.
  - If s2_err is set, the stored result is all-ones (16'hFFFF at default width) and alu_result is ignored.
- Latency: 2 cycles from the accept edge to the push. rsp_valid is visible after edge N+2 when the FIFO was empty.
- Throughput: 1 request per cycle sustained while rsp_ready = 1.
- Held inputs: alu_* outputs hold their last value when no request is accepted. No pipeline bubble is inserted.
- Credit flow: req_ready = (fifo_count + s1_valid + s2_valid) < DEPTH. This is registered-state only, with no combinational path from req_valid or rsp_ready.
  - A pop in the same cycle does not free a credit until the next cycle.
- Pop: occurs at an edge where rsp_valid && rsp_ready. The head advances; rsp_* present the next entry in the same cycle after the edge.
- Simultaneous push and pop: count is unchanged, pointers both advance. Correct with count at 1 and at DEPTH.
- Full FIFO: no push can be lost, because credits reserve space for all in-flight ops.
- Pointers: wrap modulo DEPTH. The count field is log2(DEPTH)+1 bits.
- Stable head: rsp_result/rsp_tag/rsp_err are stable while rsp_valid && !rsp_ready.
- Arithmetic: the block performs none. Results are truncated to CELL_SIZE by the ALU.
- Reset mid-operation: in-flight ops and FIFO contents are discarded. No response is produced for them after reset releases.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- When defined, adds output ports perf_issued [31:0] and perf_div0 [15:0].
  - perf_issued increments on each accepted request.
  - perf_div0 increments on each accepted request with s1_err condition true.
  - Both counters wrap modulo 2^width and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single add:
  - Stimulus: reset, then one request op=000, lhs=7, rhs=5, tag=3 with rsp_ready=1.
  - Response: rsp_valid rises after edge N+2 with rsp_result=12, rsp_tag=3, rsp_err=0. alu_op=000, alu_lhs=7, alu_rhs=5 after edge N.
- Back-to-back stream:
  - Stimulus: 8 consecutive requests, sub then xor alternating, tags 0..7, rsp_ready=1.
  - Response: one response per cycle in tag order; req_ready stays 1; results match the golden model (e.g. 10-3=7, 0x00F0^0x0FF0=0x0F00).
- Divide by zero:
  - Stimulus: op=011, lhs=9, rhs=0, tag=1, then op=100, lhs=9, rhs=4, tag=2.
  - Response: first response has rsp_err=1, rsp_result=0xFFFF; second has rsp_err=0, rsp_result=1.
- Backpressure and full:
  - Stimulus: rsp_ready=0 while req_valid is held continuously.
  - Response: exactly DEPTH=4 requests accepted, then req_ready=0 and the head stays stable.
  - Then rsp_ready=1 for 1 cycle: the head pops, and req_ready returns to 1 one cycle later.
- Simultaneous push/pop at full:
  - Stimulus: with count=4 and s2_valid=0, assert rsp_ready each cycle with requests pending.
  - Response: order is preserved across pointer wrap (16 requests, tags 0..15 mod 16); no drops or duplicates.
- Reset mid-operation:
  - Stimulus: two ops in flight and 2 entries queued; pulse reset_n low asynchronously between edges.
  - Response: rsp_valid=0 and alu_* = 0 immediately; no stale response after release; the next request completes normally.
  - With ALU_ISSUE_PERF_EN: the perf counters read 0 after reset.
